// File: rtl/mshr_refill_pkg.sv
// Shared types and derived-constant helpers for the miss-status/refill unit.
// The cache controller uses the same helpers so both sides agree on line geometry.
package mshr_refill_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } mshr_state_e;

  // Byte-offset bits inside one beat/word.
  function automatic int unsigned byte_off(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Words (beats) per cache line.
  function automatic int unsigned words(input int unsigned word_offset);
    return 32'd1 << word_offset;
  endfunction

  // Full line width in bits.
  function automatic int unsigned datamem_width(input int unsigned data_width,
                                                input int unsigned word_offset);
    return data_width << word_offset;
  endfunction

  // Constants for the default geometry (32-bit words, 4-word lines).
  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned DefWordOffset   = 2;
  localparam int unsigned DefByteOff      = byte_off(DefDataWidth);
  localparam int unsigned DefWords        = words(DefWordOffset);
  localparam int unsigned DefDatamemWidth = datamem_width(DefDataWidth, DefWordOffset);

endpackage

// File: rtl/mshr_refill.sv
// Miss-status/refill unit: fetches one cache line critical-word-first with wrap-around,
// forwards the critical word of a load miss early, merges store-miss data into the line
// and hands the finished line, base address and victim way back to the cache controller.
module mshr_refill
  import mshr_refill_pkg::*;
#(
  parameter int unsigned ADR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned WORD_OFFSET   = 2,
  parameter int unsigned DATAMEM_WIDTH = DATA_WIDTH << WORD_OFFSET,
  parameter int unsigned WAY_BITS      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  // Controller -> MSHR
  input  logic                     start_cc2mshr,
  input  logic [ADR_WIDTH-1:0]     adr_cc2mshr,
  input  logic                     rdwr_cc2mshr,
  input  logic [DATA_WIDTH-1:0]    dat_cc2mshr,
  input  logic [WAY_BITS-1:0]      way_cc2mshr,
  output logic                     busy_mshr2cc,
  // Memory port
  output logic                     req_cc2mem,
  output logic [ADR_WIDTH-1:0]     adr_cc2mem,
  input  logic                     ack_mem2cc,
  input  logic [DATA_WIDTH-1:0]    dat_mem2cc,
  // Early critical-word forward
  output logic                     fwd_mshr2cpu,
  output logic [DATA_WIDTH-1:0]    fwd_dat_mshr2cpu,
  // Completed line back to controller
  output logic                     done_mshr2cc,
  output logic [DATAMEM_WIDTH-1:0] line_mshr2cc,
  output logic [WAY_BITS-1:0]      way_mshr2cc,
  output logic [ADR_WIDTH-1:0]     adr_mshr2cc
);

  localparam int unsigned ByteOff = byte_off(DATA_WIDTH);
  localparam int unsigned Words   = words(WORD_OFFSET);
  // Keep counters at least one bit wide so a single-beat line still elaborates.
  localparam int unsigned CntW    = (WORD_OFFSET > 0) ? WORD_OFFSET : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Words - 1);
  // Byte offset of an address within its line.
  localparam logic [ADR_WIDTH-1:0] OffMask =
      ADR_WIDTH'((64'd1 << (WORD_OFFSET + ByteOff)) - 64'd1);

  mshr_state_e r_state, w_state_nxt;

  logic [ADR_WIDTH-1:0]  r_base;
  logic [CntW-1:0]       r_crit;
  logic [CntW-1:0]       r_cnt;
  logic [CntW-1:0]       r_beats;
  logic [WAY_BITS-1:0]   r_way;
  logic                  r_rdwr;
  logic [DATA_WIDTH-1:0] r_sdat;
  logic                  r_fwd;
  logic [DATA_WIDTH-1:0] r_fwd_dat;

  logic                  w_start;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_first_load;
  logic [CntW-1:0]       w_crit;
  logic [CntW-1:0]       w_cnt_inc;
  logic [DATA_WIDTH-1:0] w_slot_dat;

  // Starts and acks only count in the state that expects them.
  assign w_start      = (r_state == StIdle) && start_cc2mshr;
  assign w_beat       = (r_state == StFill) && ack_mem2cc;
  assign w_last       = w_beat && (r_beats == CntMax);
  assign w_first_load = w_beat && (r_beats == '0) && !r_rdwr;
  assign w_crit       = CntW'(adr_cc2mshr >> ByteOff) & CntMax;
  assign w_cnt_inc    = (r_cnt + CntW'(1)) & CntMax;
  // A store miss overwrites the fetched critical word with the CPU's store data.
  assign w_slot_dat   = (r_rdwr && (r_cnt == r_crit)) ? r_sdat : dat_mem2cc;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_nxt = StFill;
      StFill:  if (w_last)  w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Miss context latched at start; word counter and beat counter advance per ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base  <= '0;
      r_crit  <= '0;
      r_cnt   <= '0;
      r_beats <= '0;
      r_way   <= '0;
      r_rdwr  <= 1'b0;
      r_sdat  <= '0;
    end else if (w_start) begin
      r_base  <= adr_cc2mshr & ~OffMask;
      r_crit  <= w_crit;
      r_cnt   <= w_crit;
      r_beats <= '0;
      r_way   <= way_cc2mshr;
      r_rdwr  <= rdwr_cc2mshr;
      r_sdat  <= dat_cc2mshr;
    end else if (w_beat) begin
      r_cnt   <= w_cnt_inc;
      r_beats <= r_beats + CntW'(1);
    end
  end

  // Critical-word forward: one-cycle pulse after the first beat of a load miss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwd     <= 1'b0;
      r_fwd_dat <= '0;
    end else begin
      r_fwd <= w_first_load;
      if (w_first_load) r_fwd_dat <= dat_mem2cc;
    end
  end

  // Line assembly: one register per word slot, written when the counter selects it.
  for (genvar g = 0; g < Words; g++) begin : g_slot
    logic                  w_we;
    logic [DATA_WIDTH-1:0] r_slot;

    assign w_we = w_beat && (r_cnt == CntW'(g));

    // Slot register; not cleared between fills since every slot is rewritten.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_slot <= '0;
      end else if (w_we) begin
        r_slot <= w_slot_dat;
      end
    end

    assign line_mshr2cc[g*DATA_WIDTH +: DATA_WIDTH] = r_slot;
  end

  assign busy_mshr2cc     = (r_state != StIdle);
  assign req_cc2mem       = (r_state == StFill);
  assign adr_cc2mem       = req_cc2mem ? (r_base | (ADR_WIDTH'(r_cnt) << ByteOff)) : '0;
  assign fwd_mshr2cpu     = r_fwd;
  assign fwd_dat_mshr2cpu = r_fwd_dat;
  assign done_mshr2cc     = (r_state == StDone);
  assign way_mshr2cc      = r_way;
  assign adr_mshr2cc      = r_base;

endmodule

// File: tb/tb_mshr_refill.sv
// Scoreboard bench for mshr_refill: stimulus pushes expected beat addresses, forwards and
// completed lines into queues; monitors pop and compare whenever the DUT presents them.
module tb_mshr_refill;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 128;
  localparam int WB  = 2;
  localparam int DW2 = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 1: default geometry
  logic          start, rdwr, ack;
  logic [AW-1:0] adr_i;
  logic [DW-1:0] sdat, mdat;
  logic [WB-1:0] way_i;
  logic          busy, req, fwd, done;
  logic [AW-1:0] adr_mem, adr_o;
  logic [DW-1:0] fwd_dat;
  logic [LW-1:0] line;
  logic [WB-1:0] way_o;

  mshr_refill #(
    .ADR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_OFFSET(2), .DATAMEM_WIDTH(LW), .WAY_BITS(WB)
  ) u_dut (
    .clk(clk), .rst(rst),
    .start_cc2mshr(start), .adr_cc2mshr(adr_i), .rdwr_cc2mshr(rdwr),
    .dat_cc2mshr(sdat), .way_cc2mshr(way_i), .busy_mshr2cc(busy),
    .req_cc2mem(req), .adr_cc2mem(adr_mem), .ack_mem2cc(ack), .dat_mem2cc(mdat),
    .fwd_mshr2cpu(fwd), .fwd_dat_mshr2cpu(fwd_dat),
    .done_mshr2cc(done), .line_mshr2cc(line), .way_mshr2cc(way_o), .adr_mshr2cc(adr_o)
  );

  // DUT 2: single-beat 64-bit line
  logic           start2, rdwr2, ack2;
  logic [AW-1:0]  adr2_i;
  logic [DW2-1:0] sdat2, mdat2;
  logic [WB-1:0]  way2_i;
  logic           busy2, req2, fwd2, done2;
  logic [AW-1:0]  adr2_mem, adr2_o;
  logic [DW2-1:0] fwd2_dat, line2;
  logic [WB-1:0]  way2_o;

  mshr_refill #(
    .ADR_WIDTH(AW), .DATA_WIDTH(DW2), .WORD_OFFSET(0), .DATAMEM_WIDTH(DW2), .WAY_BITS(WB)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .start_cc2mshr(start2), .adr_cc2mshr(adr2_i), .rdwr_cc2mshr(rdwr2),
    .dat_cc2mshr(sdat2), .way_cc2mshr(way2_i), .busy_mshr2cc(busy2),
    .req_cc2mem(req2), .adr_cc2mem(adr2_mem), .ack_mem2cc(ack2), .dat_mem2cc(mdat2),
    .fwd_mshr2cpu(fwd2), .fwd_dat_mshr2cpu(fwd2_dat),
    .done_mshr2cc(done2), .line_mshr2cc(line2), .way_mshr2cc(way2_o), .adr_mshr2cc(adr2_o)
  );

  typedef struct {
    logic [DW2-1:0] dat;
    int             lat;
  } fwd_t;

  typedef struct {
    logic [LW-1:0] line;
    logic [WB-1:0] way;
    logic [AW-1:0] base;
    int            lat;
  } done_t;

  int compared   = 0;
  int mismatched = 0;
  int start_cyc  = 0;
  int start_cyc2 = 0;
  bit chk_busy   = 1'b0;
  bit chk_busy2  = 1'b0;

  logic [AW-1:0] q_adr[$];
  fwd_t          q_fwd[$];
  done_t         q_done[$];
  logic [AW-1:0] q2_adr[$];
  fwd_t          q2_fwd[$];
  done_t         q2_done[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input string what);
    compared++;
    mismatched++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor for DUT 1.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    fwd_t          f;
    done_t         d;
    if (chk_busy) begin
      chk_busy = 1'b0;
      check("busy_low_after_done", busy, 0);
    end
    if (req && ack) begin
      if (q_adr.size() == 0) flag_fail("beat_adr", "unexpected beat request");
      else begin
        e = q_adr.pop_front();
        check("beat_adr", adr_mem, e);
      end
    end
    if (fwd) begin
      if (q_fwd.size() == 0) flag_fail("fwd", "unexpected forward pulse");
      else begin
        f = q_fwd.pop_front();
        check("fwd_dat", fwd_dat, f.dat);
        check("fwd_lat", cyc - start_cyc, f.lat);
      end
    end
    if (done) begin
      if (q_done.size() == 0) flag_fail("done", "unexpected done pulse");
      else begin
        d = q_done.pop_front();
        check("done_line", line, d.line);
        check("done_way", way_o, d.way);
        check("done_base", adr_o, d.base);
        check("done_lat", cyc - start_cyc, d.lat);
        chk_busy = 1'b1;
      end
    end
  end

  // Monitor for DUT 2.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    fwd_t          f;
    done_t         d;
    if (chk_busy2) begin
      chk_busy2 = 1'b0;
      check("busy2_low_after_done", busy2, 0);
    end
    if (req2 && ack2) begin
      if (q2_adr.size() == 0) flag_fail("beat2_adr", "unexpected beat request");
      else begin
        e = q2_adr.pop_front();
        check("beat2_adr", adr2_mem, e);
      end
    end
    if (fwd2) begin
      if (q2_fwd.size() == 0) flag_fail("fwd2", "unexpected forward pulse");
      else begin
        f = q2_fwd.pop_front();
        check("fwd2_dat", fwd2_dat, f.dat);
        check("fwd2_lat", cyc - start_cyc2, f.lat);
      end
    end
    if (done2) begin
      if (q2_done.size() == 0) flag_fail("done2", "unexpected done pulse");
      else begin
        d = q2_done.pop_front();
        check("done2_line", line2, d.line);
        check("done2_way", way2_o, d.way);
        check("done2_base", adr2_o, d.base);
        check("done2_lat", cyc - start_cyc2, d.lat);
        chk_busy2 = 1'b1;
      end
    end
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) flag_fail(name, "busy never dropped");
  endtask

  // One 4-beat miss. Beats are given in issue order; gap = idle cycles before each ack.
  task automatic do_miss(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] sd,
                         input logic [WB-1:0] w,
                         input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                         input logic [DW-1:0] b2, input logic [DW-1:0] b3,
                         input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                         input logic [AW-1:0] e2, input logic [AW-1:0] e3,
                         input logic [LW-1:0] eline, input logic [AW-1:0] ebase,
                         input int gap, input bit spurious);
    logic [DW-1:0] beats[4];
    fwd_t          f;
    done_t         d;
    beats = '{b0, b1, b2, b3};
    q_adr.push_back(e0); q_adr.push_back(e1); q_adr.push_back(e2); q_adr.push_back(e3);
    if (!rw) begin
      f.dat = DW2'(b0);
      f.lat = 2 + gap;
      q_fwd.push_back(f);
    end
    d.line = eline; d.way = w; d.base = ebase; d.lat = 4 * (1 + gap) + 1;
    q_done.push_back(d);
    @(posedge clk); #1;
    start = 1'b1; adr_i = a; rdwr = rw; sdat = sd; way_i = w;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; adr_i = '0; rdwr = 1'b0; sdat = '0; way_i = '0;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        @(posedge clk); #1;
      end
      ack = 1'b1; mdat = beats[i];
      if (spurious && i == 1) begin
        start = 1'b1; adr_i = 32'hDEAD_BEE0; rdwr = 1'b1; way_i = 2'd3;
      end
      @(posedge clk); #1;
      ack = 1'b0; mdat = '0; start = 1'b0; adr_i = '0; rdwr = 1'b0; way_i = '0;
    end
    // Now in the done cycle.
    if (spurious) begin
      start = 1'b1; adr_i = 32'h0000_5550;
    end
    @(posedge clk); #1;
    start = 1'b0; adr_i = '0;
    wait_idle("miss_idle");
    if (spurious) begin
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("no_second_burst", {busy, req}, 2'b00);
    end
  endtask

  // One single-beat miss on DUT 2.
  task automatic do_miss2(input logic [AW-1:0] a, input logic rw, input logic [DW2-1:0] sd,
                          input logic [WB-1:0] w, input logic [DW2-1:0] beat,
                          input logic [AW-1:0] ebase, input logic [DW2-1:0] eline);
    fwd_t  f;
    done_t d;
    int    k;
    q2_adr.push_back(ebase);
    if (!rw) begin
      f.dat = beat;
      f.lat = 2;
      q2_fwd.push_back(f);
    end
    d.line = LW'(eline); d.way = w; d.base = ebase; d.lat = 2;
    q2_done.push_back(d);
    @(posedge clk); #1;
    start2 = 1'b1; adr2_i = a; rdwr2 = rw; sdat2 = sd; way2_i = w;
    start_cyc2 = cyc;
    @(posedge clk); #1;
    start2 = 1'b0; adr2_i = '0; rdwr2 = 1'b0; sdat2 = '0; way2_i = '0;
    ack2 = 1'b1; mdat2 = beat;
    @(posedge clk); #1;
    ack2 = 1'b0; mdat2 = '0;
    k = 0;
    while (busy2 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy2) flag_fail("miss2_idle", "busy never dropped");
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd_t f;
    rst = 1'b0;
    start = 1'b0; adr_i = '0; rdwr = 1'b0; sdat = '0; way_i = '0; ack = 1'b0; mdat = '0;
    start2 = 1'b0; adr2_i = '0; rdwr2 = 1'b0; sdat2 = '0; way2_i = '0; ack2 = 1'b0;
    mdat2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, req, fwd, done}, 4'b0000);
    check("reset_data", {line, way_o, adr_o, adr_mem, fwd_dat}, '0);
    rst = 1'b1;

    // Acks while idle must not touch the line.
    @(posedge clk); #1;
    ack = 1'b1; mdat = 32'h1234_5678;
    repeat (2) begin
      @(posedge clk); #1;
    end
    ack = 1'b0; mdat = '0;
    check("idle_ack_line", line, '0);
    check("idle_ack_busy", busy, 0);

    // Load miss, acks every other cycle, critical word 2.
    do_miss(32'hFF07_BD08, 1'b0, '0, 2'd0,
            32'hA000_0001, 32'hA111_0002, 32'hA222_0003, 32'hA333_0004,
            32'hFF07_BD08, 32'hFF07_BD0C, 32'hFF07_BD00, 32'hFF07_BD04,
            {32'hA111_0002, 32'hA000_0001, 32'hA333_0004, 32'hA222_0003},
            32'hFF07_BD00, 1, 1'b0);

    // Store miss: critical slot takes the store data, no forward.
    do_miss(32'hFFFF_FD08, 1'b1, 32'hAA8A_AAA4, 2'd3,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FD08, 32'hFFFF_FD0C, 32'hFFFF_FD00, 32'hFFFF_FD04,
            {32'hFFFF_FFFF, 32'hAA8A_AAA4, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            32'hFFFF_FD00, 0, 1'b0);

    // Back-to-back acks, word 0: done 5 cycles after start, busy low at 6.
    do_miss(32'h0000_1230, 1'b0, '0, 2'd2,
            32'hB000_0000, 32'hB111_1111, 32'hB222_2222, 32'hB333_3333,
            32'h0000_1230, 32'h0000_1234, 32'h0000_1238, 32'h0000_123C,
            {32'hB333_3333, 32'hB222_2222, 32'hB111_1111, 32'hB000_0000},
            32'h0000_1230, 0, 1'b0);

    // Starts mid-fill and on the done cycle are ignored.
    do_miss(32'h0000_2004, 1'b0, '0, 2'd1,
            32'hC000_0000, 32'hC111_0000, 32'hC222_0000, 32'hC333_0000,
            32'h0000_2004, 32'h0000_2008, 32'h0000_200C, 32'h0000_2000,
            {32'hC222_0000, 32'hC111_0000, 32'hC000_0000, 32'hC333_0000},
            32'h0000_2000, 1, 1'b1);

    // Reset after two beats of a load miss.
    q_adr.push_back(32'h0000_3008);
    q_adr.push_back(32'h0000_300C);
    f.dat = DW2'(32'hD000_0000);
    f.lat = 2;
    q_fwd.push_back(f);
    @(posedge clk); #1;
    start = 1'b1; adr_i = 32'h0000_3008; rdwr = 1'b0; way_i = 2'd1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; adr_i = '0; way_i = '0;
    ack = 1'b1; mdat = 32'hD000_0000;
    @(posedge clk); #1;
    mdat = 32'hD111_0000;
    @(posedge clk); #1;
    ack = 1'b0; mdat = '0;
    check("pre_reset_req", req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_req", req, 0);
    check("async_reset_ctrl", {busy, fwd, done}, 3'b000);
    check("async_reset_data", {line, way_o, adr_o, adr_mem, fwd_dat}, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // New store miss after reset, critical word 3 wraps to 0.
    do_miss(32'h0000_400C, 1'b1, 32'h5A5A_5A5A, 2'd2,
            32'hE000_0000, 32'hE111_0000, 32'hE222_0000, 32'hE333_0000,
            32'h0000_400C, 32'h0000_4000, 32'h0000_4004, 32'h0000_4008,
            {32'h5A5A_5A5A, 32'hE333_0000, 32'hE222_0000, 32'hE111_0000},
            32'h0000_4000, 0, 1'b0);

    // Single-beat 64-bit lines.
    do_miss2(32'h1000_0A1C, 1'b0, '0, 2'd1, 64'h0123_4567_89AB_CDEF,
             32'h1000_0A18, 64'h0123_4567_89AB_CDEF);
    do_miss2(32'h2000_0040, 1'b1, 64'hCAFE_F00D_1234_5678, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF,
             32'h2000_0040, 64'hCAFE_F00D_1234_5678);

    repeat (4) @(posedge clk);
    #1;
    if (q_adr.size() != 0 || q2_adr.size() != 0)
      flag_fail("leftover_beats", "expected beat requests never seen");
    if (q_fwd.size() != 0 || q2_fwd.size() != 0)
      flag_fail("leftover_fwd", "expected forward pulses never seen");
    if (q_done.size() != 0 || q2_done.size() != 0)
      flag_fail("leftover_done", "expected done pulses never seen");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
